// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   (IF) port and the data-memory (DM) port of the pipelined core. Each grant
//   walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE, so at most one access is ever
//   outstanding. All outputs come straight from flops.
//
//   Build option ARB_ROUND_ROBIN_EN:
//     defined   - on a tie the port that did not win last time is granted.
//     undefined - fixed priority, DM wins every tie (drains the older
//                 instruction first); last_grant is tracked but not consulted.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   // instruction-fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   // data-memory port
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   // shared memory
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // status
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   // grant identifiers, also the encoding of last_grant
   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_DM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // state and bookkeeping
   state_t             state_r,      state_s;
   logic [CNT_W-1:0]   cnt_r,        cnt_s;
   logic               grant_r,      grant_s;
   logic               last_grant_r, last_grant_s;
   logic               pick_s;

   // output registers and their next values
   logic               mem_en_r,     mem_en_s;
   logic               mem_we_r,     mem_we_s;
   logic [ADDR_W-1:0]  mem_addr_r,   mem_addr_s;
   logic [DATA_W-1:0]  mem_wdata_r,  mem_wdata_s;
   logic               if_ready_r,   if_ready_s;
   logic [DATA_W-1:0]  if_rdata_r,   if_rdata_s;
   logic               dm_ready_r,   dm_ready_s;
   logic [DATA_W-1:0]  dm_rdata_r,   dm_rdata_s;
   logic               busy_r,       busy_s;

   // Arbitration: choose which requester wins if a grant happens this cycle.
   always_comb begin
      pick_s = GRANT_IF;
`ifdef ARB_ROUND_ROBIN_EN
      if (if_req && dm_req) begin
         // tie: alternate away from whoever was served last
         pick_s = (last_grant_r == GRANT_IF) ? GRANT_DM : GRANT_IF;
      end else begin
         pick_s = dm_req ? GRANT_DM : GRANT_IF;
      end
`else
      // tie or not, DM has precedence
      pick_s = dm_req ? GRANT_DM : GRANT_IF;
`endif
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      grant_s      = grant_r;
      last_grant_s = last_grant_r;
      mem_en_s     = 1'b0;
      mem_we_s     = mem_we_r;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      if_ready_s   = 1'b0;
      if_rdata_s   = if_rdata_r;
      dm_ready_s   = 1'b0;
      dm_rdata_s   = dm_rdata_r;

      case (state_r)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               // latch the winner so the strobe appears in ISSUE
               state_s      = ST_ISSUE;
               mem_en_s     = 1'b1;
               grant_s      = pick_s;
               last_grant_s = pick_s;
               if (pick_s == GRANT_DM) begin
                  mem_we_s    = dm_we;
                  mem_addr_s  = dm_addr;
                  mem_wdata_s = dm_wdata;
               end else begin
                  // fetches never write; write data is left as it was
                  mem_we_s    = 1'b0;
                  mem_addr_s  = if_addr;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            // strobe is live this cycle; count out the remaining latency
            cnt_s   = CNT_W'(MEM_LATENCY - 1);
            state_s = ST_WAIT;
         end

         ST_WAIT: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               // mem_rdata is valid now; load it so it is registered in RESP
               state_s = ST_RESP;
               if (grant_r == GRANT_DM) begin
                  dm_ready_s = 1'b1;
                  if (!mem_we_r) begin
                     dm_rdata_s = mem_rdata;
                  end else begin
                     // stores leave the load-data register alone
                     dm_rdata_s = dm_rdata_r;
                  end
               end else begin
                  if_ready_s = 1'b1;
                  if_rdata_s = mem_rdata;
               end
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end

         ST_RESP: begin
            // ready pulse is visible this cycle; requests are sampled next
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         grant_r      <= GRANT_IF;
         last_grant_r <= GRANT_IF;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         grant_r      <= grant_s;
         last_grant_r <= last_grant_s;
      end
   end

   // Output registers; every output clears on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         if_ready_r  <= 1'b0;
         if_rdata_r  <= {DATA_W{1'b0}};
         dm_ready_r  <= 1'b0;
         dm_rdata_r  <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         if_ready_r  <= if_ready_s;
         if_rdata_r  <= if_rdata_s;
         dm_ready_r  <= dm_ready_s;
         dm_rdata_r  <= dm_rdata_s;
         busy_r      <= busy_s;
      end
   end

   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_ready  = if_ready_r;
   assign if_rdata  = if_rdata_r;
   assign dm_ready  = dm_ready_r;
   assign dm_rdata  = dm_rdata_r;
   assign busy      = busy_r;

endmodule
